app_read_arbiter: RTL
=====================

# app_read_arbiter

Read-back arbiter and sequencer for the shared DSP data bus. It sits between the per-App output registers (each App's `db_out_*` / `data_from_*_avail` pair) and the top-level bidirectional bus driver. On every qualified DSP read it waits for the Apps to respond and selects exactly one source. It then drives the bus and holds it for the length of the read strobe. It also counts collisions (more than one App responding) and no-response reads, and the DSP can read and clear those counters through the arbiter's own addresses.

## Interface
- `NUM_APPS`, default 4: number of App requesters, 1..8.
- `TIMEOUT_CYCLES`, default 3: number of cycles in WAIT before a read is declared unanswered, 1..15.
- `offset_to_add_to_ab`, default 0: added to every address-bus constant this block decodes.
- `xclk`  in  1: system clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `read_qualified`  in  1: level. High for the entire DSP read strobe.
- `write_qualified`  in  1: single-cycle write strobe.
- `ab`  in  8: DSP address bus.
- `db_in`  in  16: DSP write data.
- `app_db_out`  in  16*NUM_APPS: App data. App i occupies bits [16i+15:16i].
- `app_avail`  in  NUM_APPS: App i claims the current read.
- `db_out`  out  16: data to the top-level bus driver.
- `db_out_en`  out  1: the top level drives the DSP bus while this is high.
- `arb_busy`  out  1: high in every state except IDLE (testpoint/debug).

## Operation
- FSM states:
  - IDLE:
    - `db_out_en`=0, `db_out`=0xFFFF.
    - A rising `read_qualified` → WAIT, with the wait counter cleared.
  - WAIT: each cycle, sample `app_avail` together with the internal claim `self_hit`, where `self_hit` is `ab` == READ_ARB_STATUS or READ_ARB_LAST_ERR (plus the offset).
    - Any claim present → latch the winner into `db_out` → DRIVE.
    - More than one claim present → the collision counter increments once for this read.
    - Winner priority: `self_hit` first, then the lowest App index.
    - Wait counter reaches TIMEOUT_CYCLES with no claim → `db_out`=0xFFFF, no-response counter increments, latch `ab` into `last_err_ab` → DRIVE.
    - `read_qualified` falls during WAIT → IDLE. No counter changes, `db_out_en` is never asserted.
  - DRIVE:
    - `db_out_en`=1 and `db_out` is held constant; later `app_avail` changes are ignored.
    - `read_qualified` low → IDLE.
- A collision also latches `ab` into `last_err_ab`.
- Counters:
  - `coll_cnt[7:0]` and `noresp_cnt[7:0]` saturate at 0xFF and never wrap.
- Readable registers, addresses from the shared include:
  - READ_ARB_STATUS = {`coll_cnt`, `noresp_cnt`}.
  - READ_ARB_LAST_ERR = {8'h00, `last_err_ab`}.
- Write register:
  - `write_qualified` with `ab` == WRITE_ARB_CLEAR (plus the offset) and `db_in[0]`=1 clears both counters and `last_err_ab`.
  - If a clear and an increment fall in the same cycle, the clear wins and the counter ends at 0.
- `read_qualified` and `write_qualified` both high is illegal. Writes are still decoded; read sequencing is unaffected.

## Timing
- Values after reset: state IDLE, `db_out`=0xFFFF, `db_out_en`=0, `arb_busy`=0, both counters 0, `last_err_ab`=0x00.
- Reset is asserted at any edge (including mid-WAIT or mid-DRIVE) → the next edge shows the reset values. There is no partial count.
- Read cycle sequence:
  - `read_qualified` first high at edge N → WAIT from edge N+1.
  - Apps register their outputs at edge N+1, so `app_avail` is visible during WAIT cycle 1.
  - A claim in WAIT cycle k → `db_out` and `db_out_en` valid after edge N+1+k. Nominal k=1, so `db_out_en` rises 2 cycles after the strobe.
  - `read_qualified` falls → `db_out_en` drops one edge later.
- Worst-case latency to `db_out_en` = TIMEOUT_CYCLES+1 cycles. The DSP read strobe is sized to be at least TIMEOUT_CYCLES+3 cycles.
- Back-to-back reads need at least one cycle of `read_qualified` low. Without it, the FSM stays in DRIVE for the merged strobe.

## Structure
- READ_ARB_STATUS, READ_ARB_LAST_ERR and WRITE_ARB_CLEAR are added to the shared `Address_Bus_Defs.v`.
- FSM state encodings go in that shared include as localparams (IDLE/WAIT/DRIVE).
- One sub-module, `sat_counter8`: increment, clear with priority, saturation. It is instantiated twice.
- The priority selection is an inline `for` loop over `NUM_APPS`; it is not a separate module.

## Test plan
- App 2 asserts `app_avail` with 0x1234 one cycle after `read_qualified` → `db_out_en` rises 2 cycles after the strobe, `db_out`=0x1234 held until the strobe falls, then `db_out_en`=0 one cycle later; counters stay at 0.
- Apps 1 and 3 both claim (0xAAAA, 0x5555) → `db_out`=0xAAAA, `coll_cnt`=1, `last_err_ab`=`ab`; a subsequent READ_ARB_STATUS read returns 0x0100.
- No App claims with TIMEOUT_CYCLES=3 → `db_out_en` rises 4 cycles after the strobe with 0xFFFF, `noresp_cnt`=1.
- 300 unanswered reads → `noresp_cnt`=0xFF (saturated). Then a WRITE_ARB_CLEAR with `db_in`=0x0001 coinciding with an increment → status reads 0x0000.
- Strobe drops in WAIT cycle 1 before any claim → `db_out_en` never asserts, counters unchanged. Reset asserted during DRIVE → the next edge shows `db_out_en`=0, `db_out`=0xFFFF, counters 0.

Source files
------------

// File: rtl/app_read_arbiter_pkg.sv
// Shared definitions for the DSP read-back arbiter: its bus addresses and
// the FSM state encoding.
package app_read_arbiter_pkg;

  localparam logic [7:0] READ_ARB_STATUS   = 8'hE0;
  localparam logic [7:0] READ_ARB_LAST_ERR = 8'hE1;
  localparam logic [7:0] WRITE_ARB_CLEAR   = 8'hE2;

  localparam logic [15:0] DB_IDLE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that saturates at 0xFF; a clear overrides a
// simultaneous increment.
module sat_counter8 (
  input  logic       xclk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'h00;
    end else if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch.
  always_ff @(posedge xclk) begin
    if (!reset) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/app_read_arbiter.sv
// Read-back arbiter for the shared DSP data bus: picks one responder per
// read, holds the bus for the strobe and tracks collision/no-response events.
module app_read_arbiter
  import app_read_arbiter_pkg::*;
#(
  parameter int NUM_APPS            = 4,
  parameter int TIMEOUT_CYCLES      = 3,
  parameter int offset_to_add_to_ab = 0
) (
  input  logic                     xclk,
  input  logic                     reset,
  input  logic                     read_qualified,
  input  logic                     write_qualified,
  input  logic [7:0]               ab,
  input  logic [15:0]              db_in,
  input  logic [16*NUM_APPS-1:0]   app_db_out,
  input  logic [NUM_APPS-1:0]      app_avail,
  output logic [15:0]              db_out,
  output logic                     db_out_en,
  output logic                     arb_busy
);

  localparam logic [7:0] STATUS_AB   = 8'(READ_ARB_STATUS + offset_to_add_to_ab);
  localparam logic [7:0] LAST_ERR_AB = 8'(READ_ARB_LAST_ERR + offset_to_add_to_ab);
  localparam logic [7:0] CLEAR_AB    = 8'(WRITE_ARB_CLEAR + offset_to_add_to_ab);
  localparam logic [3:0] WAIT_LAST   = 4'(TIMEOUT_CYCLES - 1);

  arb_state_e  state_q, state_d;
  logic        rd_prev_q;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] db_out_q, db_out_d;
  logic        db_out_en_q, db_out_en_d;
  logic        arb_busy_q, arb_busy_d;
  logic [7:0]  last_err_ab_q, last_err_ab_d;

  logic [7:0]  coll_cnt, noresp_cnt;
  logic        coll_inc, noresp_inc, arb_clr;
  logic        self_hit, app_found;
  logic [15:0] self_data, app_data;
  logic [3:0]  n_claims;

  logic unused_db_in;
  assign unused_db_in = ^db_in[15:1];

  assign arb_clr   = write_qualified && (ab == CLEAR_AB) && db_in[0];
  assign self_hit  = (ab == STATUS_AB) || (ab == LAST_ERR_AB);
  assign self_data = (ab == STATUS_AB) ? {coll_cnt, noresp_cnt} : {8'h00, last_err_ab_q};

  // Lowest responding App index wins among the Apps; self_hit outranks all.
  always_comb begin
    app_found = 1'b0;
    app_data  = DB_IDLE;
    n_claims  = {3'b000, self_hit};
    for (int i = 0; i < NUM_APPS; i++) begin
      n_claims = n_claims + {3'b000, app_avail[i]};
      if (app_avail[i] && !app_found) begin
        app_found = 1'b1;
        app_data  = app_db_out[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    db_out_d      = db_out_q;
    db_out_en_d   = db_out_en_q;
    last_err_ab_d = last_err_ab_q;
    coll_inc      = 1'b0;
    noresp_inc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        db_out_d    = DB_IDLE;
        db_out_en_d = 1'b0;
        if (read_qualified && !rd_prev_q) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 4'd0;
        end
      end
      ST_WAIT: begin
        if (!read_qualified) begin
          state_d = ST_IDLE;
        end else if (self_hit || app_found) begin
          db_out_d    = self_hit ? self_data : app_data;
          db_out_en_d = 1'b1;
          state_d     = ST_DRIVE;
          if (n_claims > 4'd1) begin
            coll_inc      = 1'b1;
            last_err_ab_d = ab;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          db_out_d      = DB_IDLE;
          db_out_en_d   = 1'b1;
          noresp_inc    = 1'b1;
          last_err_ab_d = ab;
          state_d       = ST_DRIVE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_DRIVE: begin
        if (!read_qualified) begin
          state_d     = ST_IDLE;
          db_out_d    = DB_IDLE;
          db_out_en_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        db_out_d    = DB_IDLE;
        db_out_en_d = 1'b0;
      end
    endcase
    if (arb_clr) begin
      last_err_ab_d = 8'h00;
    end
    arb_busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge xclk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rd_prev_q     <= 1'b0;
      wait_cnt_q    <= 4'd0;
      db_out_q      <= DB_IDLE;
      db_out_en_q   <= 1'b0;
      arb_busy_q    <= 1'b0;
      last_err_ab_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      rd_prev_q     <= read_qualified;
      wait_cnt_q    <= wait_cnt_d;
      db_out_q      <= db_out_d;
      db_out_en_q   <= db_out_en_d;
      arb_busy_q    <= arb_busy_d;
      last_err_ab_q <= last_err_ab_d;
    end
  end

  sat_counter8 u_coll_cnt (
    .xclk  (xclk),
    .reset (reset),
    .clr   (arb_clr),
    .inc   (coll_inc),
    .count (coll_cnt)
  );

  sat_counter8 u_noresp_cnt (
    .xclk  (xclk),
    .reset (reset),
    .clr   (arb_clr),
    .inc   (noresp_inc),
    .count (noresp_cnt)
  );

  assign db_out    = db_out_q;
  assign db_out_en = db_out_en_q;
  assign arb_busy  = arb_busy_q;

endmodule
